// File: rtl/sig_mag_dec.sv
// sig_mag_dec: receive-side sign/magnitude sample expander with occupancy lock.
//
// Expands each 2-bit {sig,mag} pair into a signed WIDTH-bit level one cycle
// later. It also counts magnitude bits over windows of 2^CNTR_W valid samples.
// A hysteretic FSM raises lock after LOCK_WINS consecutive windows whose count
// lies in [OCC_LO, OCC_HI]. The FSM drops lock on the first window outside
// that range.
//
// Optional build macro SIG_MAG_DEC_BAL_EN: adds sig_stat, the sign-bit count
// per window. A window whose sign count lies outside
// 2^(CNTR_W-1) +/- 2^(CNTR_W-3) is then treated as out-of-range.
//
// Ports:
//   clk        sample clock
//   reset      asynchronous active-low reset
//   restart    synchronous clear of window, stats and FSM
//   in_valid   sig/mag pair valid this cycle
//   sig, mag   sign (1 = negative) and magnitude (1 = large) bits
//   out_valid  dat_out valid
//   dat_out    signed expanded sample
//   mag_stat   magnitude count of the last completed window
//   sig_stat   sign count of the last completed window (SIG_MAG_DEC_BAL_EN only)
//   stat_valid one-cycle pulse when the window stats update
//   lock       occupancy lock indicator
module sig_mag_dec #(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned CNTR_W    = 10,
  parameter int unsigned MAG_LEVEL = 3,
  parameter int unsigned OCC_LO    = 300,
  parameter int unsigned OCC_HI    = 376,
  parameter int unsigned LOCK_WINS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  input  logic              sig,
  input  logic              mag,
  output logic              out_valid,
  output logic [WIDTH-1:0]  dat_out,
  output logic [CNTR_W:0]   mag_stat,
  output logic              stat_valid,
`ifdef SIG_MAG_DEC_BAL_EN
  output logic [CNTR_W:0]   sig_stat,
`endif
  output logic              lock
);

  localparam int unsigned GoodW = (LOCK_WINS > 1) ? $clog2(LOCK_WINS + 1) : 1;

  localparam logic [WIDTH-1:0]  One    = WIDTH'(1);
  localparam logic [WIDTH-1:0]  MagLvl = WIDTH'(MAG_LEVEL);
  localparam logic [CNTR_W:0]   OccLo  = (CNTR_W + 1)'(OCC_LO);
  localparam logic [CNTR_W:0]   OccHi  = (CNTR_W + 1)'(OCC_HI);
  localparam logic [GoodW-1:0]  GoodTgt = GoodW'(LOCK_WINS);

  typedef enum logic [1:0] {StUnlock, StAcq, StLocked} state_e;

  state_e             state_q, state_d;
  logic [GoodW-1:0]   good_q, good_d, good_inc;
  logic [CNTR_W-1:0]  win_cntr_q;
  logic [CNTR_W:0]    mag_acc_q, mag_sum;
  logic [CNTR_W:0]    mag_stat_q;
  logic               stat_valid_q, lock_q, out_valid_q;
  logic [WIDTH-1:0]   dat_q, dat_d;
  logic               win_end, mag_ok, range_ok;

  // restart takes priority over the statistics path only.
  assign win_end = in_valid & ~restart & (&win_cntr_q);
  assign mag_sum = mag_acc_q + {{CNTR_W{1'b0}}, mag};
  assign mag_ok  = (mag_sum >= OccLo) && (mag_sum <= OccHi);

`ifdef SIG_MAG_DEC_BAL_EN
  localparam int unsigned BalLo = (1 << (CNTR_W - 1)) - (1 << (CNTR_W - 3));
  localparam int unsigned BalHi = (1 << (CNTR_W - 1)) + (1 << (CNTR_W - 3));

  logic [CNTR_W:0] sig_acc_q, sig_sum, sig_stat_q;
  logic            bal_ok;

  assign sig_sum  = sig_acc_q + {{CNTR_W{1'b0}}, sig};
  assign bal_ok   = (sig_sum >= (CNTR_W + 1)'(BalLo)) && (sig_sum <= (CNTR_W + 1)'(BalHi));
  assign range_ok = mag_ok & bal_ok;
  assign sig_stat = sig_stat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_acc_q  <= '0;
      sig_stat_q <= '0;
    end else if (restart) begin
      sig_acc_q  <= '0;
      sig_stat_q <= '0;
    end else if (in_valid) begin
      if (win_end) begin
        sig_acc_q  <= '0;
        sig_stat_q <= sig_sum;
      end else begin
        sig_acc_q  <= sig_sum;
      end
    end
  end
`else
  assign range_ok = mag_ok;
`endif

  // Expansion path: two's complement level from {sig,mag}.
  always_comb begin
    dat_d = dat_q;
    if (in_valid) begin
      unique case ({sig, mag})
        2'b00:   dat_d = One;
        2'b01:   dat_d = MagLvl;
        2'b10:   dat_d = -One;
        default: dat_d = -MagLvl;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dat_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dat_q       <= dat_d;
      out_valid_q <= in_valid;
    end
  end

  // Window counter and magnitude accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cntr_q   <= '0;
      mag_acc_q    <= '0;
      mag_stat_q   <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      stat_valid_q <= win_end;
      if (restart) begin
        win_cntr_q <= '0;
        mag_acc_q  <= '0;
        mag_stat_q <= '0;
      end else if (in_valid) begin
        win_cntr_q <= win_cntr_q + CNTR_W'(1);
        if (win_end) begin
          mag_acc_q  <= '0;
          mag_stat_q <= mag_sum;
        end else begin
          mag_acc_q  <= mag_sum;
        end
      end
    end
  end

  // Lock FSM, stepped only at window end.
  assign good_inc = good_q + GoodW'(1);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (restart) begin
      state_d = StUnlock;
      good_d  = '0;
    end else if (win_end) begin
      case (state_q)
        StUnlock: begin
          if (range_ok) begin
            good_d  = GoodW'(1);
            state_d = (LOCK_WINS == 1) ? StLocked : StAcq;
          end
        end
        StAcq: begin
          if (range_ok) begin
            good_d = good_inc;
            if (good_inc == GoodTgt) state_d = StLocked;
          end else begin
            good_d  = '0;
            state_d = StUnlock;
          end
        end
        StLocked: begin
          if (!range_ok) begin
            good_d  = '0;
            state_d = StUnlock;
          end
        end
        default: begin
          good_d  = '0;
          state_d = StUnlock;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StUnlock;
      good_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      lock_q  <= (state_d == StLocked);
    end
  end

  assign out_valid  = out_valid_q;
  assign dat_out    = dat_q;
  assign mag_stat   = mag_stat_q;
  assign stat_valid = stat_valid_q;
  assign lock       = lock_q;

endmodule

// File: tb/tb_sig_mag_dec.sv
// Directed bench for sig_mag_dec with a 16-sample window, occupancy range
// 4..7 and two good windows needed for lock.
module tb_sig_mag_dec;

  localparam int unsigned WIDTH  = 14;
  localparam int unsigned CNTR_W = 4;

  logic              clk;
  logic              reset;
  logic              restart;
  logic              in_valid;
  logic              sig;
  logic              mag;
  logic              out_valid;
  logic [WIDTH-1:0]  dat_out;
  logic [CNTR_W:0]   mag_stat;
  logic              stat_valid;
  logic              lock;
`ifdef SIG_MAG_DEC_BAL_EN
  logic [CNTR_W:0]   sig_stat;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  sig_mag_dec #(
    .WIDTH     (WIDTH),
    .CNTR_W    (CNTR_W),
    .MAG_LEVEL (3),
    .OCC_LO    (4),
    .OCC_HI    (7),
    .LOCK_WINS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .in_valid   (in_valid),
    .sig        (sig),
    .mag        (mag),
    .out_valid  (out_valid),
    .dat_out    (dat_out),
    .mag_stat   (mag_stat),
    .stat_valid (stat_valid),
`ifdef SIG_MAG_DEC_BAL_EN
    .sig_stat   (sig_stat),
`endif
    .lock       (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of input, then sample just after the capturing edge.
  task automatic send(input logic v, input logic s, input logic m);
    in_valid = v;
    sig      = s;
    mag      = m;
    @(posedge clk);
    #1;
  endtask

  // One full window: mag=1 on the last magc samples, sig=1 on the first sigc.
  task automatic window(input int magc, input int sigc, input bit gaps,
                        input bit exp_lock, input string tag);
    int early = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'(i < sigc), 1'(i >= 16 - magc));
      if (i < 15) begin
        early += int'(stat_valid);
        if (gaps) begin
          send(1'b0, 1'b0, 1'b0);
          early += int'(stat_valid);
        end
      end
    end
    check_eq({tag, " early_stat"}, 32'(early), 32'd0);
    check_eq({tag, " stat_valid"}, 32'(stat_valid), 32'd1);
    check_eq({tag, " mag_stat"}, 32'(mag_stat), 32'(magc));
    check_eq({tag, " lock"}, 32'(lock), 32'(exp_lock));
`ifdef SIG_MAG_DEC_BAL_EN
    check_eq({tag, " sig_stat"}, 32'(sig_stat), 32'(sigc));
`endif
    send(1'b0, 1'b0, 1'b0);
    check_eq({tag, " pulse_end"}, 32'(stat_valid), 32'd0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    restart = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    restart  = 1'b0;
    in_valid = 1'b0;
    sig      = 1'b0;
    mag      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst dat_out", 32'(dat_out), 32'd0);
    check_eq("rst mag_stat", 32'(mag_stat), 32'd0);
    check_eq("rst stat_valid", 32'(stat_valid), 32'd0);
    check_eq("rst lock", 32'(lock), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Expansion
    send(1'b1, 1'b0, 1'b0);
    check_eq("exp 00", 32'(dat_out), 32'h0001);
    check_eq("exp 00 valid", 32'(out_valid), 32'd1);
    send(1'b1, 1'b0, 1'b1);
    check_eq("exp 01", 32'(dat_out), 32'h0003);
    send(1'b1, 1'b1, 1'b0);
    check_eq("exp 10", 32'(dat_out), 32'h3FFF);
    send(1'b1, 1'b1, 1'b1);
    check_eq("exp 11", 32'(dat_out), 32'h3FFD);
    send(1'b0, 1'b0, 1'b0);
    check_eq("exp idle valid", 32'(out_valid), 32'd0);
    check_eq("exp idle hold", 32'(dat_out), 32'h3FFD);
    pulse_restart();

    // Window counting with gaps, then all-mag window (out of range)
    window(5, 8, 1'b1, 1'b0, "win5");
    window(16, 8, 1'b0, 1'b0, "win16");

    // Acquisition: 5, 6 -> lock at window 2
    window(5, 8, 1'b0, 1'b0, "acq a1");
    window(6, 8, 1'b0, 1'b1, "acq a2");
    pulse_restart();
    check_eq("restart lock", 32'(lock), 32'd0);

    // 5, 9, 5, 6 -> lock only at window 4
    window(5, 8, 1'b0, 1'b0, "acq b1");
    window(9, 8, 1'b0, 1'b0, "acq b2");
    window(5, 8, 1'b0, 1'b0, "acq b3");
    window(6, 8, 1'b0, 1'b1, "acq b4");

    // Loss: count 3 drops lock, one good window does not relock
    window(3, 8, 1'b0, 1'b0, "loss");
    window(5, 8, 1'b0, 1'b0, "norelock");
    window(6, 8, 1'b0, 1'b1, "relock");

    // restart on sample 10 with in_valid=1
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0, 1'b1);
    restart = 1'b1;
    send(1'b1, 1'b1, 1'b1);
    restart = 1'b0;
    check_eq("rs stat_valid", 32'(stat_valid), 32'd0);
    check_eq("rs lock", 32'(lock), 32'd0);
    check_eq("rs mag_stat", 32'(mag_stat), 32'd0);
    check_eq("rs out_valid", 32'(out_valid), 32'd1);
    check_eq("rs dat_out", 32'(dat_out), 32'h3FFD);
    window(5, 8, 1'b0, 1'b0, "post rs1");
    window(6, 8, 1'b0, 1'b1, "post rs2");

    // Async reset mid-window
    for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst out_valid", 32'(out_valid), 32'd0);
    check_eq("arst dat_out", 32'(dat_out), 32'd0);
    check_eq("arst mag_stat", 32'(mag_stat), 32'd0);
    check_eq("arst stat_valid", 32'(stat_valid), 32'd0);
    check_eq("arst lock", 32'(lock), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    window(5, 8, 1'b0, 1'b0, "post arst");

`ifdef SIG_MAG_DEC_BAL_EN
    window(6, 8, 1'b0, 1'b1, "bal lock");
    window(5, 14, 1'b0, 1'b0, "bal drop");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sig_mag_dec.md
Name: sig_mag_dec

Overview:
Receive-side counterpart of the ADC sign/magnitude quantizer. Consumes the 2-bit sig/mag sample stream, expands each pair to a signed WIDTH-bit level for the correlator and DSP chain, and measures magnitude-bit occupancy over fixed windows. A hysteretic lock FSM reports whether the upstream adaptive threshold has settled near its target occupancy.

Parameters:
WIDTH, 14, output sample width (signed)
CNTR_W, 10, window length = 2^CNTR_W valid samples
MAG_LEVEL, 3, output magnitude when mag=1 (positive, < 2^(WIDTH-1))
OCC_LO, 300, minimum in-range magnitude count per window (inclusive)
OCC_HI, 376, maximum in-range magnitude count per window (inclusive)
LOCK_WINS, 4, consecutive in-range windows required to declare lock (>=1)

Ports:
clk  in  1  sample clock (adc domain)
reset  in  1  asynchronous, active-low reset
restart  in  1  synchronous clear of window, stats and FSM
in_valid  in  1  sig/mag pair valid this cycle
sig  in  1  sign bit, 1 = negative
mag  in  1  magnitude bit, 1 = large
out_valid  out  1  dat_out valid
dat_out  out  WIDTH  signed expanded sample
mag_stat  out  CNTR_W+1  magnitude count of last completed window
stat_valid  out  1  one-cycle pulse when mag_stat updates
lock  out  1  occupancy lock indicator

Behaviour:
- Reset (reset=0): all outputs 0; window counter, magnitude accumulator, good-window counter cleared; FSM = UNLOCK.
- Expansion, latency 1: on in_valid, dat_out <= {sig,mag}: 00 -> +1, 01 -> +MAG_LEVEL, 10 -> -1, 11 -> -MAG_LEVEL, in two's complement. out_valid <= in_valid. When in_valid=0, dat_out holds its value and out_valid=0.
- Window: win_cntr (CNTR_W bits) increments once per in_valid. mag_acc (CNTR_W+1 bits) adds mag on each valid sample. Cycles without in_valid leave both unchanged.
- Window end: the cycle with in_valid=1 and win_cntr all ones.
  - The end sample is included in the count.
  - mag_stat <= mag_acc + mag and stat_valid pulses for 1 cycle.
  - mag_acc restarts at 0 and win_cntr wraps to 0.
  - Range of mag_stat: 0 .. 2^CNTR_W. No overflow is possible.
- In-range test: OCC_LO <= window count <= OCC_HI, evaluated on the window-end value.
- Lock FSM, updated only at window end; lock = (state == LOCKED), registered:
  - UNLOCK: in-range -> good = 1. If LOCK_WINS == 1 go to LOCKED, else go to ACQ. Out-of-range -> stay in UNLOCK.
  - ACQ: in-range -> good + 1. When the incremented value equals LOCK_WINS, go to LOCKED. Out-of-range -> UNLOCK, good = 0.
  - LOCKED: out-of-range -> UNLOCK, good = 0. In-range -> stay in LOCKED.
- lock changes in the same cycle that stat_valid is asserted.
- restart = 1 (synchronous) clears win_cntr, mag_acc, good and mag_stat, and sets the FSM to UNLOCK with lock = 0.
  - restart has priority over a coincident in_valid for the statistics; that sample is not counted and no stat_valid is issued.
  - The expansion path still processes that sample.
- Async reset mid-window discards the partial window. The first window after release starts at sample 0.

Optional Feature:
SIG_MAG_DEC_BAL_EN
- Defined: adds output port sig_stat (CNTR_W+1 bits). It counts sig=1 samples over the same window, updates with stat_valid, is cleared by reset and restart, and holds between updates.
- A window whose sig count lies outside 2^(CNTR_W-1) +/- 2^(CNTR_W-3) is treated as out-of-range by the lock FSM, regardless of the magnitude count.
- Undefined: port absent; lock depends on magnitude count only.

Test Plan:
- Expansion, MAG_LEVEL=3, WIDTH=14: drive pairs 00,01,10,11 with in_valid=1 -> one cycle later dat_out = 1, 3, -1 (0x3FFF), -3 (0x3FFD); out_valid follows in_valid.
- Window count, CNTR_W=4: 16 valid samples with mag=1 on 5 of them, including the last, and idle gaps in between -> single stat_valid pulse on sample 16, mag_stat = 5; all-mag window -> mag_stat = 16.
- Lock acquisition, CNTR_W=4, OCC_LO=4, OCC_HI=7, LOCK_WINS=2: window counts 5, 6 -> lock rises at end of window 2. Counts 5, 9, 5, 6 -> lock only at end of window 4.
- Lock loss: while locked, a window with count 3 -> lock falls at that window end; the next single in-range window does not relock.
- restart asserted on sample 10 of a window, with in_valid=1 -> no stat_valid; lock = 0; the next 16 valid samples form a complete new window. Async reset mid-window -> all outputs 0.
- With SIG_MAG_DEC_BAL_EN, CNTR_W=4: window with mag count 5 and sig count 14 -> sig_stat = 14 and the window is treated as out-of-range (lock drops).
